// File: rtl/fma_pkg.sv
// Shared types and widths for the FMA significand datapath.
// The stage-1 payload struct is sized from the package widths, so NF/TAGW are set here.
package fma_pkg;

    typedef enum logic [2:0] {
        FRM_RNE = 3'b000,
        FRM_RTZ = 3'b001,
        FRM_RDN = 3'b010,
        FRM_RUP = 3'b011,
        FRM_RMM = 3'b100
    } frm_e;

    // Product/addend window: room for the full product plus guard bits on both sides.
    function automatic int sum_width(input int nf);
        return 3 * nf + 6;
    endfunction

    localparam int NF   = 52;
    localparam int SW   = sum_width(NF);
    localparam int TAGW = 5;

    typedef struct packed {
        logic [SW:0]      pre_sum;
        logic             p_sign;
        logic             a_sign;
        logic             inv_a;
        logic             kill_prod;
        logic [2:0]       frm;
        logic [TAGW-1:0]  tag;
    } s1_payload_t;

endpackage

// File: rtl/fma_sum_core.sv
// Combinational back half of the significand add: two's-complement PreSum to
// sign-magnitude, plus IEEE sign selection for exact-zero and addend-only results.
module fma_sum_core
    import fma_pkg::*;
(
    input  logic [SW:0]   i_pre_sum,
    input  logic          i_ps,
    input  logic          i_as,
    input  logic          i_inv_a,
    input  logic          i_kill_prod,
    input  logic [2:0]    i_frm,
    output logic [SW-1:0] o_sm,
    output logic          o_ss,
    output logic          o_sum_zero
);

    logic          w_neg;
    logic [SW-1:0] w_neg_mag;

    // Only an effective subtraction can wrap negative; bit SW is the borrow.
    assign w_neg      = i_inv_a & ~i_kill_prod & i_pre_sum[SW];
    assign w_neg_mag  = (~i_pre_sum[SW-1:0]) + 1'b1;
    assign o_sm       = w_neg ? w_neg_mag : i_pre_sum[SW-1:0];
    assign o_sum_zero = (o_sm == '0);

    always_comb begin
        o_ss = i_ps ^ w_neg;
        if (i_kill_prod) begin
            o_ss = i_as;
        end else if (o_sum_zero) begin
            o_ss = i_inv_a ? (i_frm == FRM_RDN) : i_ps;
        end
    end

endmodule

// File: rtl/fma_sum_stage.sv
// Two-stage pipelined significand adder with valid/ready, flush and tag pass-through.
// Stage 1 forms the SW+1 bit two's-complement sum; stage 2 registers the sign-magnitude result.
module fma_sum_stage
    import fma_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [SW-1:0]   Pm,
    input  logic [SW-1:0]   Am,
    input  logic            Ps,
    input  logic            As,
    input  logic            InvA,
    input  logic            KillProd,
    input  logic [2:0]      Frm,
    input  logic [TAGW-1:0] TagIn,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [SW-1:0]   Sm,
    output logic            Ss,
    output logic            SumZero,
    output logic [TAGW-1:0] TagOut
);

    logic            r_v1;
    logic            r_v2;
    s1_payload_t     r_s1;
    logic [SW-1:0]   r_sm;
    logic            r_ss;
    logic            r_sum_zero;
    logic [TAGW-1:0] r_tag_out;

    logic            w_en1;
    logic            w_en2;
    logic [SW:0]     w_am_inv;
    logic [SW:0]     w_pre_sum;
    s1_payload_t     w_s1_d;
    logic [SW-1:0]   w_sm;
    logic            w_ss;
    logic            w_sum_zero;

    assign w_en2   = ~r_v2 | OutReady;
    assign w_en1   = ~r_v1 | w_en2;
    assign InReady = w_en1;

    // Subtraction as Pm + ~Am + 1 over SW+1 bits; the top bit then flags a negative result.
    assign w_am_inv  = InvA ? {1'b1, ~Am} : {1'b0, Am};
    assign w_pre_sum = KillProd ? {1'b0, Am}
                                : ({1'b0, Pm} + w_am_inv + {{SW{1'b0}}, InvA});

    assign w_s1_d = '{pre_sum:   w_pre_sum,
                      p_sign:    Ps,
                      a_sign:    As,
                      inv_a:     InvA,
                      kill_prod: KillProd,
                      frm:       Frm,
                      tag:       TagIn};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else begin
            if (Flush) begin
                r_v1 <= 1'b0;
            end else if (w_en1) begin
                r_v1 <= InValid;
            end
            if (w_en1) begin
                r_s1 <= w_s1_d;
            end
        end
    end

    fma_sum_core u_core (
        .i_pre_sum   (r_s1.pre_sum),
        .i_ps        (r_s1.p_sign),
        .i_as        (r_s1.a_sign),
        .i_inv_a     (r_s1.inv_a),
        .i_kill_prod (r_s1.kill_prod),
        .i_frm       (r_s1.frm),
        .o_sm        (w_sm),
        .o_ss        (w_ss),
        .o_sum_zero  (w_sum_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2       <= 1'b0;
            r_sm       <= '0;
            r_ss       <= 1'b0;
            r_sum_zero <= 1'b0;
            r_tag_out  <= '0;
        end else begin
            if (Flush) begin
                r_v2 <= 1'b0;
            end else if (w_en2) begin
                r_v2 <= r_v1;
            end
            if (w_en2) begin
                r_sm       <= w_sm;
                r_ss       <= w_ss;
                r_sum_zero <= w_sum_zero;
                r_tag_out  <= r_s1.tag;
            end
        end
    end

    assign OutValid = r_v2;
    assign Sm       = r_sm;
    assign Ss       = r_ss;
    assign SumZero  = r_sum_zero;
    assign TagOut   = r_tag_out;

    // Both operands are below 2^(SW-1), so an effective addition can never carry into bit SW.
    a_no_add_carry: assert property (@(posedge clk) disable iff (!reset_n)
        (r_v1 && !r_s1.inv_a && !r_s1.kill_prod) |-> !r_s1.pre_sum[SW]);

endmodule

// File: tb/tb_fma_sum_stage.sv
// Scoreboard bench for fma_sum_stage: the driver queues expected results on acceptance,
// a negedge monitor compares them whenever the stage presents a result.
module tb_fma_sum_stage;
    import fma_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic [SW-1:0]   Pm;
    logic [SW-1:0]   Am;
    logic            Ps;
    logic            As;
    logic            InvA;
    logic            KillProd;
    logic [2:0]      Frm;
    logic [TAGW-1:0] TagIn;
    logic            OutValid;
    logic            OutReady;
    logic [SW-1:0]   Sm;
    logic            Ss;
    logic            SumZero;
    logic [TAGW-1:0] TagOut;

    fma_sum_stage dut (
        .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Pm(Pm), .Am(Am), .Ps(Ps), .As(As), .InvA(InvA), .KillProd(KillProd), .Frm(Frm),
        .TagIn(TagIn), .OutValid(OutValid), .OutReady(OutReady), .Sm(Sm), .Ss(Ss),
        .SumZero(SumZero), .TagOut(TagOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0]   sm;
        logic            ss;
        logic            zero;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && OutValid === 1'b1) begin
            if (q.size() == 0) begin
                if (OutReady) check("unexpected_output", {{(SW-TAGW){1'b0}}, TagOut}, '1);
            end else begin
                check("sm",       Sm,      q[0].sm);
                check("ss",       Ss,      q[0].ss);
                check("sum_zero", SumZero, q[0].zero);
                check("tag",      TagOut,  q[0].tag);
                if (OutReady) begin
                    void'(q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic set_in(input logic [SW-1:0] pm, input logic [SW-1:0] am, input logic ps,
                          input logic as_, input logic inva, input logic kill,
                          input logic [2:0] frm, input logic [TAGW-1:0] tag);
        Pm = pm; Am = am; Ps = ps; As = as_; InvA = inva; KillProd = kill;
        Frm = frm; TagIn = tag; InValid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [SW-1:0] pm, input logic [SW-1:0] am, input logic ps,
                        input logic as_, input logic inva, input logic kill,
                        input logic [2:0] frm, input logic [TAGW-1:0] tag,
                        input logic [SW-1:0] esm, input logic ess, input logic ezero,
                        input bit track);
        exp_t e;
        int   k = 0;
        set_in(pm, am, ps, as_, inva, kill, frm, tag);
        @(negedge clk);
        while (!InReady && k < 50) begin
            k++;
            @(negedge clk);
        end
        check("send_accept", InReady, 1);
        if (InReady) begin
            n_acc++;
            if (track) begin
                e.sm = esm; e.ss = ess; e.zero = ezero; e.tag = tag;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            k++;
            @(negedge clk);
        end
        check("drain", q.size() == 0, 1);
    endtask

    logic [SW-1:0] big;
    int            acc0;

    initial begin
        reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        Pm = '0; Am = '0; Ps = 0; As = 0; InvA = 0; KillProd = 0; Frm = '0; TagIn = '0;
        big = '1;
        big = big >> 1;
        #12;
        check("rst_outvalid", OutValid, 0);
        check("rst_sm",       Sm,       0);
        check("rst_ss",       Ss,       0);
        check("rst_sumzero",  SumZero,  0);
        check("rst_tag",      TagOut,   0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_inready", InReady, 1);

        //    pm    am    ps as inv kill frm     tag  exp_sm exp_ss zero
        send(100,  30,   0, 1, 1, 0, 3'b000, 1,  70,    0, 0, 1);
        send(30,   100,  0, 1, 1, 0, 3'b000, 2,  70,    1, 0, 1);
        send(30,   100,  1, 0, 1, 0, 3'b000, 3,  70,    0, 0, 1);
        send(64,   64,   0, 1, 1, 0, 3'b010, 4,  0,     1, 1, 1);
        send(64,   64,   0, 1, 1, 0, 3'b000, 5,  0,     0, 1, 1);
        send(0,    0,    1, 1, 0, 0, 3'b000, 6,  0,     1, 1, 1);
        send(999,  5,    0, 1, 1, 1, 3'b000, 7,  5,     1, 0, 1);
        send(200,  55,   1, 1, 0, 0, 3'b001, 8,  255,   1, 0, 1);
        send(big,  big,  0, 0, 0, 0, 3'b000, 9,  big + big, 0, 0, 1);
        send(0,    big,  0, 1, 1, 0, 3'b000, 10, big,   1, 0, 1);
        send(17,   17,   1, 0, 1, 0, 3'b011, 11, 0,     0, 1, 1);
        send(17,   17,   1, 0, 1, 0, 3'b111, 12, 0,     0, 1, 1);
        send(7,    0,    0, 1, 1, 1, 3'b000, 13, 0,     1, 1, 1);
        InValid = 1'b0;
        drain();

        // Backpressure: two ops fill the pipe, the third must wait.
        @(posedge clk); #1;
        OutReady = 1'b0;
        pop_cyc.delete();
        acc0 = n_acc;
        send(10, 1, 0, 1, 1, 0, 3'b000, 1, 9,  0, 0, 1);
        send(20, 2, 0, 1, 1, 0, 3'b000, 2, 18, 0, 0, 1);
        set_in(30, 3, 0, 1, 1, 0, 3'b000, 3);
        repeat (3) begin
            @(negedge clk);
            check("stall_inready", InReady, 0);
        end
        check("stall_accepted", n_acc - acc0, 2);
        @(posedge clk); #1;
        OutReady = 1'b1;
        send(30, 3, 0, 1, 1, 0, 3'b000, 3, 27, 0, 0, 1);
        send(40, 4, 0, 1, 1, 0, 3'b000, 4, 36, 0, 0, 1);
        InValid = 1'b0;
        drain();
        check("bp_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("bp_back_to_back", pop_cyc[i] - pop_cyc[i-1], 1);

        // Flush with one op in each stage and a new op offered the same cycle.
        @(posedge clk); #1;
        OutReady = 1'b0;
        send(50, 5, 0, 1, 1, 0, 3'b000, 20, 0, 0, 0, 0);
        send(60, 6, 0, 1, 1, 0, 3'b000, 21, 0, 0, 0, 0);
        set_in(70, 7, 0, 1, 1, 0, 3'b000, 22);
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        InValid = 1'b0;
        check("flush_outvalid", OutValid, 0);
        check("flush_inready",  InReady,  1);
        OutReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_quiet", OutValid, 0);
        end

        // Asynchronous reset with a result held at the output.
        @(posedge clk); #1;
        OutReady = 1'b0;
        send(30, 100, 0, 1, 1, 0, 3'b000, 9, 0, 0, 0, 0);
        InValid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_valid", OutValid, 1);
        check("pre_rst_tag",   TagOut,   9);
        check("pre_rst_sm",    Sm,       70);
        check("pre_rst_ss",    Ss,       1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_outvalid", OutValid, 0);
        check("arst_sm",       Sm,       0);
        check("arst_ss",       Ss,       0);
        check("arst_sumzero",  SumZero,  0);
        check("arst_tag",      TagOut,   0);
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("arst_inready", InReady, 1);
        OutReady = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_quiet", OutValid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
